// File: rtl/st_frame_scheduler.sv
// st_frame_scheduler: frame-granular 2:1 Avalon-ST arbiter for RGB565 video.
// Switches sources only on frame boundaries and aborts stalled frames with a dummy eop beat.
module st_frame_scheduler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] src0_data,
    input  logic        src0_valid,
    input  logic        src0_sop,
    input  logic        src0_eop,
    output logic        src0_ready,
    input  logic [15:0] src1_data,
    input  logic        src1_valid,
    input  logic        src1_sop,
    input  logic        src1_eop,
    output logic        src1_ready,
    output logic [15:0] dout_data,
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop,
    input  logic        dout_ready,
    output logic        grant,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [15:0] frame_cnt,
    output logic [7:0]  abort_cnt
);
    typedef enum logic [1:0] {IDLE, PASS, ABORT} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d, last_q, last_d;
    logic [1:0]  mode_q, mode_d;
    logic [19:0] tmo_q, tmo_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [7:0]  acnt_q, acnt_d;
    logic [1:0]  md, elig, hold, valid, sop, eop, rdy;
    logic [1:0][15:0] data;
    logic        gv;

    assign valid = {src1_valid, src0_valid};
    assign sop   = {src1_sop, src0_sop};
    assign eop   = {src1_eop, src0_eop};
    assign data  = {src1_data, src0_data};
    // live mode only matters while idle; a running frame keeps the mode it started with
    assign md    = (state_q == IDLE) ? mode : mode_q;
    assign elig  = {md != 2'd0, md != 2'd1};
    assign hold  = elig & valid & sop;
    assign gv    = valid[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mode_d      = mode_q;
        tmo_d       = tmo_q;
        fcnt_d      = fcnt_q;
        acnt_d      = acnt_q;
        rdy         = ~elig;
        dout_data   = 16'h0000;
        dout_valid  = 1'b0;
        dout_sop    = 1'b0;
        dout_eop    = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (state_q)
            IDLE: begin
                rdy   = ~hold;
                tmo_d = 20'd0;
                if (|hold) begin
                    state_d = PASS;
                    grant_d = (&hold) ? (mode == 2'd2 ? ~last_q : 1'b0) : hold[1];
                    mode_d  = mode;
                end
            end
            PASS: begin
                rdy[grant_q] = dout_ready;
                dout_data    = data[grant_q];
                dout_valid   = gv;
                dout_sop     = sop[grant_q];
                dout_eop     = eop[grant_q];
                tmo_d        = gv ? 20'd0 : tmo_q + 20'd1;
                if (gv && dout_ready && eop[grant_q]) begin
                    frame_done = 1'b1;
                    fcnt_d     = fcnt_q + 16'd1;
                    last_d     = grant_q;
                    state_d    = IDLE;
                end else if (!gv && tmo_q == TIMEOUT_CYCLES - 20'd1) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                rdy[grant_q] = 1'b0;
                dout_valid   = 1'b1;
                dout_eop     = 1'b1;
                if (dout_ready) begin
                    frame_abort = 1'b1;
                    acnt_d      = acnt_q + {7'd0, ~&acnt_q};
                    last_d      = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            mode_q  <= 2'd0;
            tmo_q   <= 20'd0;
            fcnt_q  <= 16'd0;
            acnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            tmo_q   <= tmo_d;
            fcnt_q  <= fcnt_d;
            acnt_q  <= acnt_d;
        end
    end

    // readies are forced low while in reset so every output reads 0
    assign src0_ready = rdy[0] & rst_n;
    assign src1_ready = rdy[1] & rst_n;
    assign grant      = grant_q;
    assign busy       = state_q != IDLE;
    assign frame_cnt  = fcnt_q;
    assign abort_cnt  = acnt_q;
endmodule

// File: tb/tb_st_frame_scheduler.sv
// tb_st_frame_scheduler: randomized frame traffic on both sources checked every cycle
// against a rule-level reference model of the scheduler.
module tb_st_frame_scheduler;
    localparam int TO = 8;

    logic        clk = 1'b0, rst_n = 1'b0, dout_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] s_data [2];
    logic [1:0]  s_valid = 2'b00, s_sop = 2'b00, s_eop = 2'b00, rdy;
    logic [15:0] dout_data, frame_cnt;
    logic        dout_valid, dout_sop, dout_eop, grant, busy, frame_done, frame_abort;
    logic [7:0]  abort_cnt;

    int n_cmp = 0, n_bad = 0;
    int m_st, m_starve, m_fc, m_ac;
    bit m_g, m_last;
    logic [1:0] m_mode;
    int left [2], quiet [2];
    bit acc [2];

    always #5 clk = ~clk;

    st_frame_scheduler #(.TIMEOUT_CYCLES(20'd8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .src0_data(s_data[0]), .src0_valid(s_valid[0]), .src0_sop(s_sop[0]), .src0_eop(s_eop[0]), .src0_ready(rdy[0]),
        .src1_data(s_data[1]), .src1_valid(s_valid[1]), .src1_sop(s_sop[1]), .src1_eop(s_eop[1]), .src1_ready(rdy[1]),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_ready(dout_ready),
        .grant(grant), .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort),
        .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit elig(int i, logic [1:0] md);
        return md == 2'd2 || md == 2'd3 || int'(md) == i;
    endfunction

    task automatic model_reset();
        m_st = 0; m_g = 0; m_last = 1; m_mode = 0; m_starve = 0; m_fc = 0; m_ac = 0;
        acc[0] = 0; acc[1] = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"}, {30'd0, rdy}, 0);
        chk({tag, "_dout"}, {13'd0, dout_valid, dout_sop, dout_eop}, 0);
        chk({tag, "_data"}, {16'd0, dout_data}, 0);
        chk({tag, "_flags"}, {28'd0, grant, busy, frame_done, frame_abort}, 0);
        chk({tag, "_cnts"}, {8'd0, frame_cnt, abort_cnt}, 0);
    endtask

    // Avalon-ST sources: a beat stays put until accepted; frames of 1..6 beats,
    // occasional orphan beats and mid-frame stalls around the timeout length.
    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (!(s_valid[i] && !acc[i])) begin
                if (quiet[i] > 0) begin
                    quiet[i]--;
                    s_valid[i] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    s_valid[i] = 0;
                end else begin
                    s_valid[i] = 1;
                    s_data[i] = 16'($urandom);
                    if (left[i] == 0) begin
                        if ($urandom_range(0, 7) == 0) begin
                            s_sop[i] = 0; s_eop[i] = 0;
                        end else begin
                            left[i] = $urandom_range(1, 6);
                            s_sop[i] = 1; s_eop[i] = (left[i] == 1);
                            left[i]--;
                        end
                    end else begin
                        s_sop[i] = 0; s_eop[i] = (left[i] == 1);
                        left[i]--;
                        if (left[i] > 0 && $urandom_range(0, 9) == 0) quiet[i] = $urandom_range(TO - 2, TO + 2);
                    end
                end
            end
        end
        dout_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_cycle();
        logic [1:0] md;
        bit g, ev, es, ee, ed, ea, h0, h1;
        logic [15:0] edata;
        md = (m_st == 0) ? mode : m_mode;
        g = m_g;
        ev = 0; es = 0; ee = 0; ed = 0; ea = 0; edata = 0;
        if (m_st == 1) begin
            ev = s_valid[g]; es = s_sop[g]; ee = s_eop[g]; edata = s_data[g];
            ed = s_valid[g] && dout_ready && s_eop[g];
        end else if (m_st == 2) begin
            ev = 1; ee = 1; ea = dout_ready;
        end
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, ev});
        if (m_st != 0) begin
            chk("dout_data", {16'd0, dout_data}, {16'd0, edata});
            chk("dout_sop", {31'd0, dout_sop}, {31'd0, es});
            chk("dout_eop", {31'd0, dout_eop}, {31'd0, ee});
        end
        for (int i = 0; i < 2; i++) begin
            if (m_st == 0) begin
                if (s_valid[i]) chk(i == 0 ? "rdy0_idle" : "rdy1_idle", {31'd0, rdy[i]}, {31'd0, !(elig(i, md) && s_sop[i])});
            end else begin
                chk(i == 0 ? "rdy0_busy" : "rdy1_busy", {31'd0, rdy[i]},
                    {31'd0, (i == int'(g)) ? (m_st == 1 && dout_ready) : !elig(i, md)});
            end
        end
        chk("frame_done", {31'd0, frame_done}, {31'd0, ed});
        chk("frame_abort", {31'd0, frame_abort}, {31'd0, ea});
        chk("busy", {31'd0, busy}, {31'd0, m_st != 0});
        chk("grant", {31'd0, grant}, {31'd0, g});
        chk("frame_cnt", {16'd0, frame_cnt}, 32'(m_fc));
        chk("abort_cnt", {24'd0, abort_cnt}, 32'(m_ac));
        for (int i = 0; i < 2; i++) acc[i] = s_valid[i] && rdy[i];
        case (m_st)
            0: begin
                h0 = elig(0, mode) && s_valid[0] && s_sop[0];
                h1 = elig(1, mode) && s_valid[1] && s_sop[1];
                if (h0 || h1) begin
                    m_g = (h0 && h1) ? (mode == 2'd2 ? !m_last : 1'b0) : h1;
                    m_mode = mode; m_starve = 0; m_st = 1;
                end
            end
            1: begin
                if (s_valid[g]) begin
                    m_starve = 0;
                    if (dout_ready && s_eop[g]) begin
                        m_fc = (m_fc + 1) % 65536; m_last = g; m_st = 0;
                    end
                end else begin
                    m_starve++;
                    if (m_starve == TO) m_st = 2;
                end
            end
            default: if (dout_ready) begin
                m_ac = (m_ac < 255) ? m_ac + 1 : 255; m_last = g; m_st = 0;
            end
        endcase
    endtask

    task automatic step();
        drive();
        #3;
        check_cycle();
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 0;
        #1 check_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #1 check_zero({tag, "_held"});
        #1 rst_n = 1;
        model_reset();
        step();
    endtask

    initial begin
        s_data[0] = 0; s_data[1] = 0;
        left[0] = 0; left[1] = 0; quiet[0] = 0; quiet[1] = 0;
        model_reset();
        #3 check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        step();
        for (int cyc = 0; cyc < 3600; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 1600) mode = 2'(cyc / 400);
            else if (cyc < 2800 && cyc % 23 == 0) mode = 2'($urandom_range(0, 3));
            else if (cyc >= 2800) mode = 2'(2 + (cyc / 400) % 2);
            step();
            if ((cyc == 1000 || cyc == 2600) && m_st == 1) pulse_reset("rst_mid");
            else if (cyc == 1001 || cyc == 2601) pulse_reset("rst_late");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
